// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_ctrl : frame sequencer gating samples into the radix-4 FFT chain |
// | Optional macro FFT_FRAME_CTRL_GAP_CHK_EN enables strict (gap-free) blocks. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_frame_ctrl #(
  parameter int PIPE_LAT = 64,
  parameter int LDN_MIN  = 4,
  parameter int LDN_MAX  = 11
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [3:0] ldn_i,
  input  logic [7:0] nblk_i,
  input  logic       data_val_i,
  output logic       data_val_o,
  output logic       block_sync_o,
  output logic       stage_sync_o,
  output logic       last_o,
  output logic [3:0] ldn_rg_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int FW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [10:0]     smp_cnt, smp_nxt;
  logic [7:0]      blk_cnt, blk_nxt;
  logic [7:0]      blk_last, blk_last_nxt;
  logic [FW-1:0]   flush_cnt, flush_nxt;
  logic [3:0]      ldn_nxt;
  logic [11:0]     n_m1;
  logic            gap_err;
  logic            dv_nxt, stage_nxt, block_nxt, last_nxt, done_nxt, err_nxt;

  assign n_m1   = (12'd1 << ldn_rg_o) - 12'd1;
  assign busy_o = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    smp_nxt      = smp_cnt;
    blk_nxt      = blk_cnt;
    blk_last_nxt = blk_last;
    flush_nxt    = flush_cnt;
    ldn_nxt      = ldn_rg_o;
    dv_nxt       = 1'b0;
    stage_nxt    = 1'b0;
    block_nxt    = 1'b0;
    last_nxt     = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
`ifdef FFT_FRAME_CTRL_GAP_CHK_EN
    gap_err = (state == RUN) && !data_val_i && (smp_cnt != '0);
`else
    gap_err = 1'b0;
`endif

    if (abort_i || gap_err) begin
      state_nxt = IDLE;
      smp_nxt   = '0;
      blk_nxt   = '0;
      flush_nxt = '0;
      err_nxt   = gap_err;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (int'(ldn_i) >= LDN_MIN && int'(ldn_i) <= LDN_MAX) begin
              ldn_nxt      = ldn_i;
              // nblk_i = 0 wraps to 255, i.e. 256 blocks
              blk_last_nxt = nblk_i - 8'd1;
              smp_nxt      = '0;
              blk_nxt      = '0;
              state_nxt    = RUN;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (data_val_i) begin
            dv_nxt    = 1'b1;
            stage_nxt = (smp_cnt == '0);
            block_nxt = (smp_cnt == '0) && (blk_cnt == '0);
            if (smp_cnt == n_m1[10:0]) begin
              smp_nxt = '0;
              if (blk_cnt == blk_last) begin
                last_nxt  = 1'b1;
                blk_nxt   = '0;
                flush_nxt = FW'(PIPE_LAT - 1);
                state_nxt = FLUSH;
              end else begin
                blk_nxt = blk_cnt + 8'd1;
              end
            end else begin
              smp_nxt = smp_cnt + 11'd1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            flush_nxt = flush_cnt - FW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state        <= IDLE;
      smp_cnt      <= '0;
      blk_cnt      <= '0;
      blk_last     <= '0;
      flush_cnt    <= '0;
      ldn_rg_o     <= 4'(LDN_MIN);
      data_val_o   <= 1'b0;
      stage_sync_o <= 1'b0;
      block_sync_o <= 1'b0;
      last_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      smp_cnt      <= smp_nxt;
      blk_cnt      <= blk_nxt;
      blk_last     <= blk_last_nxt;
      flush_cnt    <= flush_nxt;
      ldn_rg_o     <= ldn_nxt;
      data_val_o   <= dv_nxt;
      stage_sync_o <= stage_nxt;
      block_sync_o <= block_nxt;
      last_o       <= last_nxt;
      done_o       <= done_nxt;
      err_o        <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// Directed self-checking bench for fft_frame_ctrl.
module tb_fft_frame_ctrl;

  localparam int PIPE_LAT = 64;

  logic       clk_sys = 1'b0;
  logic       rst_sys_n;
  logic       start_i, abort_i, data_val_i;
  logic [3:0] ldn_i;
  logic [7:0] nblk_i;
  logic       data_val_o, block_sync_o, stage_sync_o, last_o;
  logic [3:0] ldn_rg_o;
  logic       busy_o, done_o, err_o;

  int checks   = 0;
  int failures = 0;
  bit gap_mode;
  bit seen_done;

  always #5 clk_sys = ~clk_sys;

  fft_frame_ctrl #(.PIPE_LAT(PIPE_LAT), .LDN_MIN(4), .LDN_MAX(11)) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .ldn_i        (ldn_i),
    .nblk_i       (nblk_i),
    .data_val_i   (data_val_i),
    .data_val_o   (data_val_o),
    .block_sync_o (block_sync_o),
    .stage_sync_o (stage_sync_o),
    .last_o       (last_o),
    .ldn_rg_o     (ldn_rg_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] ldn, input logic [7:0] nblk);
    start_i = 1'b1;
    ldn_i   = ldn;
    nblk_i  = nblk;
    tick();
    start_i = 1'b0;
  endtask

  // Feeds count samples; checks framing against a frame of total samples of npts each.
  task automatic feed(input int count, input int npts, input int total, input bit gap);
    for (int i = 0; i < count; i++) begin
      data_val_i = 1'b1;
      tick();
      chk("dv_o", data_val_o, 1);
      chk("stage_sync", stage_sync_o, (i % npts) == 0);
      chk("block_sync", block_sync_o, i == 0);
      chk("last", last_o, i == total - 1);
      data_val_i = 1'b0;
      if (gap && i < count - 1) begin
        tick();
        chk("dv_o_gap", data_val_o, 0);
      end
    end
    data_val_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 1; k <= PIPE_LAT; k++) begin
      tick();
      chk("flush_done", done_o, k == PIPE_LAT);
      chk("flush_dv", data_val_o, 0);
      chk("flush_busy", busy_o, k != PIPE_LAT);
    end
    tick();
    chk("done_pulse_end", done_o, 0);
  endtask

  initial begin
    rst_sys_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; data_val_i = 1'b0;
    ldn_i = 4'd0; nblk_i = 8'd0;
    tick(); tick();
    rst_sys_n = 1'b1;
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_ldn", ldn_rg_o, 4);
    chk("rst_outs", {data_val_o, block_sync_o, stage_sync_o, last_o, done_o, err_o}, 0);

    // Basic frame: 2 blocks of 16
    do_start(4'd4, 8'd2);
    chk("b_busy", busy_o, 1);
    chk("b_ldn", ldn_rg_o, 4);
    feed(32, 16, 32, 1'b0);
    wait_done();

    // Gapped frame (back-to-back when strict gap checking is built in)
`ifdef FFT_FRAME_CTRL_GAP_CHK_EN
    gap_mode = 1'b0;
`else
    gap_mode = 1'b1;
`endif
    do_start(4'd6, 8'd1);
    chk("g_ldn", ldn_rg_o, 6);
    feed(64, 64, 64, gap_mode);
    wait_done();

    // Illegal sizes
    do_start(4'd3, 8'd1);
    chk("ill3_err", err_o, 1);
    chk("ill3_busy", busy_o, 0);
    chk("ill3_ldn", ldn_rg_o, 6);
    tick();
    chk("ill3_err_end", err_o, 0);
    do_start(4'd12, 8'd1);
    chk("ill12_err", err_o, 1);
    chk("ill12_busy", busy_o, 0);
    chk("ill12_ldn", ldn_rg_o, 6);
    tick();
    chk("ill12_err_end", err_o, 0);

    // Abort mid-block, with an in-flight sample
    do_start(4'd11, 8'd1);
    feed(100, 2048, 2048, 1'b0);
    abort_i = 1'b1; data_val_i = 1'b1;
    tick();
    abort_i = 1'b0; data_val_i = 1'b0;
    chk("ab_busy", busy_o, 0);
    chk("ab_dv", data_val_o, 0);
    chk("ab_ldn", ldn_rg_o, 11);
    seen_done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      seen_done |= done_o;
    end
    chk("ab_no_done", seen_done, 0);
    do_start(4'd5, 8'd1);
    chk("ab_new_ldn", ldn_rg_o, 5);
    feed(32, 32, 32, 1'b0);
    wait_done();

    // Start while busy is ignored
    do_start(4'd4, 8'd1);
    for (int i = 0; i < 16; i++) begin
      data_val_i = 1'b1;
      start_i = (i == 5);
      ldn_i   = 4'd7;
      tick();
      start_i = 1'b0;
      chk("sb_last", last_o, i == 15);
      if (i == 5) begin
        chk("sb_err", err_o, 0);
        chk("sb_ldn", ldn_rg_o, 4);
        chk("sb_busy", busy_o, 1);
      end
    end
    data_val_i = 1'b0;
    wait_done();

    // Abort and start together in IDLE: abort wins
    abort_i = 1'b1; start_i = 1'b1; ldn_i = 4'd8; nblk_i = 8'd1;
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    chk("as_busy", busy_o, 0);
    chk("as_ldn", ldn_rg_o, 4);
    chk("as_err", err_o, 0);
    tick();
    chk("as_busy2", busy_o, 0);

`ifdef FFT_FRAME_CTRL_GAP_CHK_EN
    // Mid-block gap aborts with err_o
    do_start(4'd4, 8'd2);
    feed(5, 16, 32, 1'b0);
    tick();
    chk("gc_err", err_o, 1);
    chk("gc_busy", busy_o, 0);
    tick();
    chk("gc_err_end", err_o, 0);
    // Gap at a block boundary is allowed
    do_start(4'd4, 8'd2);
    feed(16, 16, 32, 1'b0);
    tick();
    chk("gb_err", err_o, 0);
    chk("gb_busy", busy_o, 1);
    for (int i = 16; i < 32; i++) begin
      data_val_i = 1'b1;
      tick();
      chk("gb_stage", stage_sync_o, i == 16);
      chk("gb_last", last_o, i == 31);
    end
    data_val_i = 1'b0;
    wait_done();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
